// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch front end: fetch PC, memory req/ack, instruction FIFO

module if_fetch_queue #(
  parameter int               ISIZE    = 16,
  parameter int               DSIZE    = 16,
  parameter int               DEPTH    = 4,
  parameter logic [ISIZE-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       mem_req,
  output logic [ISIZE-1:0]           mem_addr,
  input  logic                       mem_ack,
  input  logic [DSIZE-1:0]           mem_rdata,
  input  logic                       redirect,
  input  logic [ISIZE-1:0]           redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [DSIZE-1:0]           inst,
  output logic [ISIZE-1:0]           inst_pc,
  output logic [ISIZE-1:0]           inst_pcplus1,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_e;

  state_e           state_q, state_d;
  logic [ISIZE-1:0] fpc_q, fpc_d;
  logic [ISIZE-1:0] drop_addr_q, drop_addr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [DSIZE-1:0] inst_mem_q [DEPTH];
  logic [ISIZE-1:0] pc_mem_q   [DEPTH];
  logic [ISIZE-1:0] pcp_mem_q  [DEPTH];

  logic             pop;
  logic             push;
  logic [ISIZE-1:0] fpc_plus1;

  assign fpc_plus1    = fpc_q + 1'b1;
  assign inst_valid   = (count_q != '0);
  assign inst         = inst_mem_q[rd_ptr_q];
  assign inst_pc      = pc_mem_q[rd_ptr_q];
  assign inst_pcplus1 = pcp_mem_q[rd_ptr_q];
  assign count        = count_q;
  assign mem_req      = (state_q != S_IDLE);
  assign mem_addr     = (state_q == S_DROP) ? drop_addr_q : fpc_q;

  // Next-state: fetch sequencing, FIFO occupancy, redirect flush taking priority over push/pop
  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    drop_addr_d = drop_addr_q;
    pop         = inst_valid && inst_ready;
    push        = (state_q == S_REQ) && mem_ack && !redirect
                  && ((count_q != FULL) || pop);
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);

    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      fpc_d    = redirect_pc;
    end

    case (state_q)
      S_IDLE: begin
        if (!redirect && (count_q < FULL)) state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect) begin
          if (mem_ack) begin
            state_d = S_IDLE;
          end else begin
            // the outstanding request must still complete at its original address
            drop_addr_d = fpc_q;
            state_d     = S_DROP;
          end
        end else if (mem_ack) begin
          fpc_d = fpc_plus1;
          if (count_d >= FULL) state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (mem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pointer and FIFO storage registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      fpc_q       <= RESET_PC;
      drop_addr_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
        pcp_mem_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      drop_addr_q <= drop_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      if (push) begin
        inst_mem_q[wr_ptr_q] <= mem_rdata;
        pc_mem_q[wr_ptr_q]   <= fpc_q;
        pcp_mem_q[wr_ptr_q]  <= fpc_plus1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - randomized bench for if_fetch_queue against a queue-based fetch model

module tb_if_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic [15:0] inst_pcplus1;
  logic [2:0]  count;

  always #5 clk = ~clk;

  if_fetch_queue dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_pcplus1(inst_pcplus1), .count(count)
  );

  typedef struct { logic [15:0] w; logic [15:0] pc; } ent_t;

  // Reference model: queued instructions, fetch pointer, one in-flight request
  ent_t        mq[$];
  logic [15:0] m_fpc  = '0;
  logic [15:0] m_addr = '0;
  bit          m_busy = 0;
  bit          m_disc = 0;

  // Memory and consumer behaviour knobs
  int          age = 0;
  int          lat = 0;
  int          lat_mode = 0;
  int          ready_mode = 1;
  bit          redir_pend = 0;
  int          redir_mode = 0;
  logic [15:0] redir_target = '0;
  bit          redir_rand = 0;
  bit          stray_ack = 0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_lat();
    return (lat_mode < 0) ? int'($urandom_range(3)) : lat_mode;
  endfunction

  // Per cycle: compare DUT against model at negedge, drive inputs, advance model at posedge
  initial begin
    logic [15:0] exp_pcp;
    bit          ack_v, fire, pop, can_start;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("mem_req", mem_req, m_busy);
        if (m_busy) chk("mem_addr", mem_addr, m_addr);
        chk("inst_valid", inst_valid, mq.size() != 0);
        chk("count", count, mq.size());
        if (mq.size() != 0) begin
          exp_pcp = mq[0].pc + 16'd1;
          chk("inst", inst, mq[0].w);
          chk("inst_pc", inst_pc, mq[0].pc);
          chk("inst_pcplus1", inst_pcplus1, exp_pcp);
        end
        ack_v = mem_req && (age >= lat);
        if (!mem_req && stray_ack) begin
          ack_v     = 1'b1;
          stray_ack = 0;
        end
        mem_ack    = ack_v;
        mem_rdata  = 16'($urandom);
        inst_ready = (ready_mode == 2) ? 1'($urandom_range(1)) : (ready_mode == 1);
        fire = redir_pend && ((redir_mode == 0) ||
                              (redir_mode == 1 && mem_req && ack_v) ||
                              (redir_mode == 2 && mem_req && !ack_v));
        if (fire) begin
          redir_pend  = 0;
          redirect    = 1'b1;
          redirect_pc = redir_target;
        end else if (redir_rand && $urandom_range(15) == 0) begin
          redirect = 1'b1;
          case ($urandom_range(2))
            0:       redirect_pc = 16'($urandom);
            1:       redirect_pc = 16'hFFFE;
            default: redirect_pc = 16'hFFFF;
          endcase
        end else begin
          redirect    = 1'b0;
          redirect_pc = 16'($urandom);
        end
      end else begin
        mem_ack  = 1'b0;
        redirect = 1'b0;
      end

      @(posedge clk);
      if (!rst) begin
        mq.delete();
        m_fpc  = 16'h0000;
        m_busy = 0;
        m_disc = 0;
        age    = 0;
        lat    = pick_lat();
      end else begin
        pop       = (mq.size() != 0) && inst_ready;
        can_start = mq.size() < DEPTH;
        if (redirect) begin
          mq.delete();
          m_fpc = redirect_pc;
          if (m_busy) begin
            if (mem_ack) begin
              m_busy = 0;
              m_disc = 0;
            end else begin
              m_disc = 1;
            end
          end
        end else if (!m_busy) begin
          if (pop) void'(mq.pop_front());
          if (can_start) begin
            m_busy = 1;
            m_addr = m_fpc;
          end
        end else if (mem_ack) begin
          if (pop) void'(mq.pop_front());
          if (m_disc) begin
            m_busy = 0;
            m_disc = 0;
          end else begin
            mq.push_back('{w: mem_rdata, pc: m_fpc});
            m_fpc = m_fpc + 16'd1;
            if (mq.size() < DEPTH) m_addr = m_fpc;
            else m_busy = 0;
          end
        end else if (pop) begin
          void'(mq.pop_front());
        end
        if (mem_req && mem_ack) begin
          age = 0;
          lat = pick_lat();
        end else if (mem_req) begin
          age++;
        end else begin
          age = 0;
        end
      end
    end
  end

  // Asynchronous reset pulse, off the clock edges, with an immediate check of cleared outputs
  task automatic do_reset();
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_inst", inst, 16'h0);
    chk("rst_inst_pc", inst_pc, 16'h0);
    chk("rst_inst_pcplus1", inst_pcplus1, 16'h0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_redirect_fired();
    int n = 0;
    while (redir_pend && n < 40) begin
      step();
      n++;
    end
    if (redir_pend) begin
      chk("redirect_timeout", 1'b1, 1'b0);
      redir_pend = 0;
    end
  endtask

  initial begin
    int n;

    // zero-wait memory, always-ready consumer
    lat_mode   = 0;
    ready_mode = 1;
    do_reset();
    step();
    chk("t1_idle_after_release", mem_req, 1'b0);
    step();
    chk("t1_first_req", mem_req, 1'b1);
    chk("t1_first_addr", mem_addr, 16'h0000);
    step();
    chk("t1_valid", inst_valid, 1'b1);
    chk("t1_inst_pc", inst_pc, 16'h0000);
    chk("t1_pcplus1", inst_pcplus1, 16'h0001);
    chk("t1_addr1", mem_addr, 16'h0001);
    repeat (8) step();
    chk("t1_count_steady", count, 3'd1);

    // consumer stalled: FIFO fills then one pop lets fetch resume at addr 4
    ready_mode = 0;
    do_reset();
    repeat (10) step();
    chk("t2_full", count, 3'd4);
    chk("t2_req_off", mem_req, 1'b0);
    chk("t2_head", inst_pc, 16'h0000);
    ready_mode = 1;
    step();
    ready_mode = 0;
    step();
    chk("t2_after_pop_count", count, 3'd3);
    chk("t2_after_pop_head", inst_pc, 16'h0001);
    chk("t2_after_pop_req", mem_req, 1'b0);
    step();
    chk("t2_refetch_req", mem_req, 1'b1);
    chk("t2_refetch_addr", mem_addr, 16'h0004);
    repeat (4) step();

    // 3-cycle memory latency
    lat_mode   = 2;
    ready_mode = 1;
    do_reset();
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_addr_held", mem_addr, 16'h0000);
    end
    step();
    chk("t3_next_addr", mem_addr, 16'h0001);
    chk("t3_first_pc", inst_pc, 16'h0000);

    // redirect to 0x0040 while addr 2 is outstanding
    n = 0;
    while (!(mem_req && mem_addr == 16'h0002) && n < 40) begin
      step();
      n++;
    end
    chk("t4_reach_addr2", mem_addr, 16'h0002);
    redir_target = 16'h0040;
    redir_mode   = 2;
    redir_pend   = 1;
    wait_redirect_fired();
    step();
    chk("t4_flushed", count, 3'd0);
    chk("t4_drop_req", mem_req, 1'b1);
    chk("t4_drop_addr", mem_addr, 16'h0002);
    n = 0;
    while (!(mem_req && mem_addr != 16'h0002) && n < 40) begin
      step();
      n++;
    end
    chk("t4_new_addr", mem_addr, 16'h0040);
    n = 0;
    while (!inst_valid && n < 40) begin
      step();
      n++;
    end
    chk("t4_first_pc", inst_pc, 16'h0040);

    // redirect to 0xFFFF coincident with ack, zero-wait memory
    lat_mode     = 0;
    redir_target = 16'hFFFF;
    redir_mode   = 1;
    redir_pend   = 1;
    wait_redirect_fired();
    step();
    chk("t5_flushed_valid", inst_valid, 1'b0);
    chk("t5_flushed_count", count, 3'd0);
    n = 0;
    while (!mem_req && n < 20) begin
      step();
      n++;
    end
    chk("t5_addr_ffff", mem_addr, 16'hFFFF);
    n = 0;
    while (!inst_valid && n < 20) begin
      step();
      n++;
    end
    chk("t5_pc_ffff", inst_pc, 16'hFFFF);
    chk("t5_pcplus1_wrap", inst_pcplus1, 16'h0000);
    chk("t5_addr_wrap", mem_addr, 16'h0000);
    step();
    chk("t5_pc_wrap", inst_pc, 16'h0000);

    // reset in the middle of a slow fetch, then a stray ack while idle
    lat_mode   = 3;
    ready_mode = 0;
    repeat (5) step();
    do_reset();
    stray_ack = 1;
    step();
    step();
    chk("t6_req_after_reset", mem_req, 1'b1);
    chk("t6_addr_after_reset", mem_addr, 16'h0000);
    chk("t6_count_after_reset", count, 3'd0);

    // randomized traffic with occasional resets
    lat_mode   = -1;
    ready_mode = 2;
    redir_rand = 1;
    for (int r = 0; r < 4; r++) begin
      repeat (800) step();
      do_reset();
    end
    repeat (200) step();
    redir_rand = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch front end directly upstream of the pipelined 16-bit datapath.
- Owns the fetch PC and issues requests to the instruction memory over a req/ack handshake that tolerates variable latency.
- Buffers returned instruction words with their PC and PC+1 in a small FIFO, and presents them to the datapath's decode/control stage over valid/ready.
- Flushes and restarts on a branch/jump redirect from the datapath.

Parameters:
ISIZE, 16, instruction address width
DSIZE, 16, instruction word width
DEPTH, 4, FIFO entries; power of two, at least 2
RESET_PC, 16'h0000, first address fetched after reset

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-low (0 = in reset)
mem_req  out  1  fetch request to instruction memory
mem_addr  out  ISIZE  fetch address; stable while mem_req=1
mem_ack  in  1  memory returns mem_rdata this cycle; ends the request
mem_rdata  in  DSIZE  instruction word, valid when mem_ack=1
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  ISIZE  new fetch address
inst_valid  out  1  FIFO head is valid
inst_ready  in  1  consumer accepts head this cycle
inst  out  DSIZE  head instruction word
inst_pc  out  ISIZE  head instruction address
inst_pcplus1  out  ISIZE  inst_pc+1, modulo 2^ISIZE
count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=0, asynchronous): fpc=RESET_PC, FIFO empty (count=0), state=IDLE, mem_req=0, inst_valid=0; inst, inst_pc and inst_pcplus1 read 0.
- States: IDLE, REQ, DROP. mem_req=1 in REQ and DROP. mem_addr=fpc in REQ and the latched in-flight address in DROP.
- IDLE:
  - redirect: fpc<=redirect_pc, stay IDLE.
  - Otherwise, if count<DEPTH: go to REQ next cycle.
- REQ, no ack: hold mem_addr; mem_req stays 1.
- REQ, mem_ack and no redirect:
  - Push {mem_rdata, fpc, fpc+1}; fpc<=fpc+1, wrapping 16'hFFFF to 0.
  - Stay in REQ if post-update occupancy is below DEPTH, else go to IDLE.
  - Zero-wait memory therefore sustains one fetch per cycle.
- REQ, redirect without ack: in-flight request must still complete. Latch the in-flight address, fpc<=redirect_pc, flush FIFO, go to DROP.
- REQ, redirect with mem_ack in the same cycle: discard the data, flush FIFO, fpc<=redirect_pc, go to IDLE.
- DROP:
  - mem_ack: discard the data, go to IDLE.
  - Further redirect: fpc<=redirect_pc, stay in DROP; if it coincides with mem_ack, go to IDLE.
- FIFO:
  - Head is shown combinationally; pop occurs when inst_valid and inst_ready.
  - Push and pop in the same cycle: count unchanged, even when full, because the freed slot absorbs the push.
  - Push is suppressed when count=DEPTH and no pop, which cannot occur by the room rule.
- Redirect has priority over push and pop. In a redirect cycle inst_valid is still driven from the pre-flush head, but the consumer must ignore it; count=0 the next cycle.
- Latency: first mem_req 1 cycle after rst deasserts. inst_valid is asserted the cycle after mem_ack.
- Reset mid-request: everything clears immediately. A later mem_ack for the abandoned request is ignored because state is IDLE.
- Pointer arithmetic is modulo DEPTH; occupancy is tracked by a separate counter, never by pointer compare.

Test Plan:
- Release reset, zero-wait memory (mem_ack same cycle as mem_req), inst_ready=1: mem_addr sequence 0,1,2,3…; inst_pc follows 1 cycle behind; inst_pcplus1=inst_pc+1; count stays at most 1.
- inst_ready=0, zero-wait memory: exactly 4 fetches (addr 0–3), count=4, mem_req drops to 0. Then inst_ready=1 for 1 cycle: pops addr 0, fetch of addr 4 follows, FIFO order preserved.
- Memory with 3-cycle ack latency: mem_addr held constant for 3 cycles; each word appears with its correct PC; no duplicate or skipped addresses.
- Redirect to 16'h0040 while a request to addr 2 is outstanding with 3-cycle latency: FIFO empties next cycle; the addr-2 data is dropped on its ack; next mem_addr=16'h0040; first inst_pc after the flush=16'h0040.
- Redirect to 16'hFFFF coincident with mem_ack: data discarded. Next fetches are 16'hFFFF then 16'h0000; inst_pcplus1 for 16'hFFFF is 16'h0000.
- rst pulsed low mid-fetch, asynchronously and not aligned to clk: mem_req=0, inst_valid=0 and count=0 immediately; after release, first mem_addr=RESET_PC.
